// File: rtl/apb_regfile_slave_if.sv
// APB completer-side bus bundle for the register-file slave.
// The master modport drives the request, the slave modport returns data and status.
interface apb_regfile_slave_if #(
  parameter int AddrWidth = 32
);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [AddrWidth-1:0] paddr;
  logic [31:0]          pwdata;
  logic [3:0]           pstrb;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB slave that bridges transfers onto a simple register-file port with
// a programmable number of wait states, range/alignment checking and abort handling.
module apb_regfile_slave #(
  parameter int NumWords   = 64,
  parameter int WaitStates = 1,
  parameter int AddrWidth  = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  apb_regfile_slave_if.slave          apb,
  output logic                        rf_w_en,
  output logic [$clog2(NumWords)-1:0] rf_offset,
  output logic [31:0]                 rf_data_in,
  output logic [3:0]                  rf_strb,
  input  logic [31:0]                 rf_data_out
);

  localparam logic [3:0]           WaitInit = 4'(WaitStates);
  localparam logic [AddrWidth-1:0] MaxAddr  = AddrWidth'(NumWords - 4);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 pready_q;
  logic                 write_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           strb_q;
  logic                 err;

  // pready_q is raised on the edge where the wait counter reaches zero, so it
  // is high for exactly the ACCESS cycle in which cnt_q == 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      pready_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      strb_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          pready_q <= 1'b0;
          if (apb.psel && !apb.penable) begin
            write_q  <= apb.pwrite;
            addr_q   <= apb.paddr;
            wdata_q  <= apb.pwdata;
            strb_q   <= apb.pstrb;
            cnt_q    <= WaitInit;
            pready_q <= (WaitInit == 4'd0);
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (pready_q) begin
            pready_q <= 1'b0;
            state_q  <= IDLE;
          end else if (!(apb.psel && apb.penable)) begin
            // Master withdrew the transfer before completion.
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            pready_q <= (cnt_q == 4'd1);
          end
        end
        default: begin
          pready_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign err = (addr_q[1:0] != 2'b00) || (addr_q > MaxAddr);

  assign apb.pready  = pready_q;
  assign apb.pslverr = pready_q && err;
  assign apb.prdata  = (pready_q && !write_q && !err) ? rf_data_out : 32'd0;

  assign rf_w_en    = pready_q && write_q && !err && (strb_q != 4'd0);
  assign rf_offset  = addr_q[$clog2(NumWords)-1:0];
  assign rf_data_in = wdata_q;
  assign rf_strb    = strb_q;

endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 Parameter NumWords, default 64: register-file size in bytes; sets rf_offset width to $clog2(NumWords).
REQ-002 Parameter WaitStates, default 1: number of extra ACCESS cycles inserted before pready (range 0..15).
REQ-003 Parameter AddrWidth, default 32: width of paddr.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 psel  input  1  APB select.
REQ-007 penable  input  1  APB access phase.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  AddrWidth  byte address.
REQ-010 pwdata  input  32  write data.
REQ-011 pstrb  input  4  write byte strobes.
REQ-012 prdata  output  32  read data, valid when pready=1.
REQ-013 pready  output  1  transfer completion.
REQ-014 pslverr  output  1  transfer error, valid when pready=1.
REQ-015 rf_w_en  output  1  register-file write enable, one-cycle pulse.
REQ-016 rf_offset  output  $clog2(NumWords)  register-file byte offset.
REQ-017 rf_data_in  output  32  register-file write data.
REQ-018 rf_strb  output  4  register-file byte strobes.
REQ-019 rf_data_out  input  32  register-file combinational read data.

Function
REQ-020 The block SHALL implement a two-state FSM: IDLE, ACCESS.
REQ-021 In IDLE, psel=1 and penable=0 (setup phase) SHALL latch paddr, pwrite, pwdata, pstrb, load wait counter cnt=WaitStates, and move to ACCESS next edge.
REQ-022 In ACCESS with cnt!=0, cnt SHALL decrement by 1 per cycle; pready=0.
REQ-023 In ACCESS with cnt==0, pready SHALL be 1 for exactly that cycle and the FSM SHALL return to IDLE next edge.
REQ-024 Latency: pready high in cycle setup+1+WaitStates; WaitStates=0 gives zero-wait APB transfer.
REQ-025 Error condition err SHALL be set when latched paddr[1:0]!=0 or latched paddr > NumWords-4.
REQ-026 rf_offset SHALL equal latched paddr[$clog2(NumWords)-1:0]; rf_data_in and rf_strb SHALL equal latched pwdata and pstrb.
REQ-027 rf_w_en SHALL be 1 only in the pready cycle of a write with err=0 and latched pstrb!=0.
REQ-028 Write with pstrb=0 SHALL complete with pready, pslverr=0, and no rf_w_en pulse.
REQ-029 On read completion prdata SHALL equal rf_data_out when err=0, and 32'h0 when err=1; pstrb on reads SHALL be ignored.
REQ-030 pslverr SHALL equal err during the pready cycle and 0 otherwise; prdata SHALL be 0 outside read pready cycles.
REQ-031 If psel or penable is 0 in any ACCESS cycle before pready, the transfer SHALL abort: return to IDLE, no rf_w_en, no pready.
REQ-032 pready, pslverr, rf_w_en SHALL be 0 in IDLE.
REQ-033 Back-to-back transfers SHALL be supported: a setup phase in the cycle after pready starts a new transfer with identical latency.

Reset
REQ-034 reset_n=0 SHALL asynchronously force IDLE, cnt=0, all latched fields 0, and prdata, pready, pslverr, rf_w_en, rf_offset, rf_data_in, rf_strb to 0.
REQ-035 Reset asserted mid-ACCESS SHALL abort the transfer with no rf_w_en pulse; first transfer after release behaves as from power-up.

Verification
REQ-036 WaitStates=1, write paddr=0x08, pwdata=0xA5A5_1234, pstrb=4'hF -> pready in cycle setup+2, rf_w_en single pulse, rf_offset=8, pslverr=0.
REQ-037 Read paddr=0x08 with rf_data_out=0xDEAD_BEEF -> prdata=0xDEAD_BEEF in pready cycle, pslverr=0, no rf_w_en.
REQ-038 Write paddr=0x3E (misaligned) and paddr=0x40 (out of range, NumWords=64) -> pready with pslverr=1, no rf_w_en; read paddr=0x40 -> prdata=0.
REQ-039 WaitStates=0, three back-to-back writes to 0x00/0x04/0x3C -> each pready in cycle after setup, three rf_w_en pulses, no lost transfer.
REQ-040 psel dropped in second ACCESS cycle (WaitStates=3) -> no pready, no rf_w_en, FSM in IDLE; next transfer completes normally.
REQ-041 reset_n pulsed low during ACCESS of a write -> all outputs 0 immediately, no rf_w_en pulse, next read completes with WaitStates latency.
